// File: rtl/gactx_pkg.sv
// Shared constants and helpers for the GACTX read-path blocks.
package gactx_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int NUM_REQ_DEF = 4;
    localparam int MAX_OUT_DEF = 8;

    // Widths for the default build; parameterised modules derive their own.
    localparam int RR_IDX_W  = $clog2(NUM_REQ_DEF);
    localparam int OUT_CNT_W = $clog2(MAX_OUT_DEF) + 1;

endpackage

// File: rtl/gactx_id_fifo.sv
// In-order FIFO of granted client indices; head is the owner of the next R burst.
module gactx_id_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gactx_rd_arbiter.sv
// Round-robin AR arbiter with in-order R steering for the GACTX read master.
module gactx_rd_arbiter
    import gactx_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [NUM_REQ-1:0]              req_arvalid,
    output logic [NUM_REQ-1:0]              req_arready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_araddr,
    input  logic [NUM_REQ*AXI_LEN_W-1:0]    req_arlen,
    output logic [NUM_REQ-1:0]              req_rvalid,
    input  logic [NUM_REQ-1:0]              req_rready,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic                            req_rlast,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
    output logic [AXI_LEN_W-1:0]            m_axi_arlen,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready,
    input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
    input  logic                            m_axi_rlast,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                            idle,
    output logic                            err_unexpected_r
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
    logic [NUM_REQ-1:0][AXI_LEN_W-1:0]  len_v;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] head;
    logic             found;
    logic             slot_free;
    logic             grant;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    // Packed 2-D views share the flat bus layout (client i at [i*W +: W]).
    assign addr_v = req_araddr;
    assign len_v  = req_arlen;

    // Slot frees in the same cycle its contents are accepted; the limit
    // ignores a same-cycle pop on purpose.
    assign slot_free = !m_axi_arvalid || m_axi_arready;
    assign grant     = slot_free && (outstanding < CNT_W'(MAX_OUTSTANDING)) && found;
    assign pop       = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    // Round-robin search: clients at/after rr_ptr first, then the wrapped part.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_arvalid[i] && (i >= int'(rr_ptr))) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_arvalid[i] && (i < int'(rr_ptr))) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
    end

    // Per-client handshakes: AR ready to the winner, R valid to the FIFO head.
    always_comb begin
        req_arready = '0;
        req_rvalid  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_arready[i] = grant && (winner == IDX_W'(i));
            req_rvalid[i]  = m_axi_rvalid && !fifo_empty && (head == IDX_W'(i));
        end
    end

    assign m_axi_rready = !fifo_empty && req_rready[head];
    assign req_rdata    = m_axi_rdata;
    assign req_rlast    = m_axi_rlast;
    assign idle         = (outstanding == '0) && !m_axi_arvalid && !(|req_arvalid);

    // AR slot register and round-robin pointer advance.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            rr_ptr        <= '0;
        end else if (grant) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= addr_v[winner];
            m_axi_arlen   <= len_v[winner];
            rr_ptr        <= (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
        end
    end

    // Sticky flag for an R beat with no burst on record.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                          err_unexpected_r <= 1'b0;
        else if (m_axi_rvalid && fifo_empty) err_unexpected_r <= 1'b1;
    end

    // FIFO occupancy is exactly the number of granted, uncompleted bursts.
    gactx_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk       (aclk),
        .rst       (areset),
        .push      (grant),
        .push_data (winner),
        .pop       (pop),
        .head      (head),
        .count     (outstanding),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_gactx_rd_arbiter.sv
// Directed bench for gactx_rd_arbiter with hand-computed expectations.
module tb_gactx_rd_arbiter;

    logic             aclk;
    logic             areset;
    logic [3:0]       req_arvalid;
    logic [3:0]       req_arready;
    logic [3:0][63:0] req_araddr;
    logic [3:0][7:0]  req_arlen;
    logic [3:0]       req_rvalid;
    logic [3:0]       req_rready;
    logic [511:0]     req_rdata;
    logic             req_rlast;
    logic             m_axi_arvalid;
    logic             m_axi_arready;
    logic [63:0]      m_axi_araddr;
    logic [7:0]       m_axi_arlen;
    logic             m_axi_rvalid;
    logic             m_axi_rready;
    logic [511:0]     m_axi_rdata;
    logic             m_axi_rlast;
    logic [3:0]       outstanding;
    logic             idle;
    logic             err_unexpected_r;

    int n_tests = 0;
    int n_fail  = 0;

    gactx_rd_arbiter dut (
        .aclk             (aclk),
        .areset           (areset),
        .req_arvalid      (req_arvalid),
        .req_arready      (req_arready),
        .req_araddr       (req_araddr),
        .req_arlen        (req_arlen),
        .req_rvalid       (req_rvalid),
        .req_rready       (req_rready),
        .req_rdata        (req_rdata),
        .req_rlast        (req_rlast),
        .m_axi_arvalid    (m_axi_arvalid),
        .m_axi_arready    (m_axi_arready),
        .m_axi_araddr     (m_axi_araddr),
        .m_axi_arlen      (m_axi_arlen),
        .m_axi_rvalid     (m_axi_rvalid),
        .m_axi_rready     (m_axi_rready),
        .m_axi_rdata      (m_axi_rdata),
        .m_axi_rlast      (m_axi_rlast),
        .outstanding      (outstanding),
        .idle             (idle),
        .err_unexpected_r (err_unexpected_r)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] i, input logic [63:0] a, input logic [7:0] l);
        req_araddr[i] = a;
        req_arlen[i]  = l;
    endtask

    initial begin
        int cnt;
        int beat;
        int steps;
        areset        = 1'b1;
        req_arvalid   = '0;
        req_araddr    = '0;
        req_arlen     = '0;
        req_rready    = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rlast   = 1'b0;
        #3;
        // ---- reset state
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_unexpected_r, 0);
        chk("rst_idle", idle, 1);
        chk("rst_req_arready", req_arready, 0);
        chk("rst_req_rvalid", req_rvalid, 0);
        tick();
        areset = 1'b0;

        // ---- fairness: all clients requesting, grants 0,1,2,3,0,1
        for (int i = 0; i < 4; i++) set_req(2'(i), 64'h1_0000 * (i + 1), 8'd0);
        req_arvalid   = 4'b1111;
        m_axi_arready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            #1;
            chk("fair_grant", req_arready, 4'b0001 << (g % 4));
            if (g > 0) chk("fair_araddr", m_axi_araddr, 64'h1_0000 * ((g - 1) % 4 + 1));
            tick();
        end
        req_arvalid = '0;
        #1;
        chk("fair_last_araddr", m_axi_araddr, 64'h2_0000);
        chk("fair_outstanding", outstanding, 6);
        tick();
        req_rready   = 4'b1111;
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        for (int g = 0; g < 6; g++) begin
            m_axi_rdata = 512'(g + 16);
            #1;
            chk("fair_route", req_rvalid, 4'b0001 << (g % 4));
            tick();
        end
        m_axi_rvalid = 1'b0;
        #1;
        chk("fair_drained", outstanding, 0);

        // ---- single request: client 0, 0x1000, arlen 3
        set_req(2'd0, 64'h1000, 8'd3);
        req_arvalid = 4'b0001;
        #1;
        chk("single_grant", req_arready, 4'b0001);
        tick();
        req_arvalid = '0;
        #1;
        chk("single_arvalid", m_axi_arvalid, 1);
        chk("single_araddr", m_axi_araddr, 64'h1000);
        chk("single_arlen", m_axi_arlen, 3);
        chk("single_out1", outstanding, 1);
        tick();
        chk("single_ar_drop", m_axi_arvalid, 0);
        m_axi_rvalid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m_axi_rdata = 512'(64'hBEEF_0000 + b);
            m_axi_rlast = (b == 3);
            #1;
            chk("single_rvalid", req_rvalid, 4'b0001);
            chk("single_rready", m_axi_rready, 1);
            chk("single_rdata", req_rdata, 512'(64'hBEEF_0000 + b));
            if (b < 3) chk("single_out_mid", outstanding, 1);
            tick();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        #1;
        chk("single_out0", outstanding, 0);
        chk("single_idle", idle, 1);

        // ---- outstanding limit: R idle, only client 0 requesting
        set_req(2'd0, 64'h4000, 8'd0);
        req_arvalid = 4'b0001;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_arready[0]) cnt++;
            tick();
        end
        chk("limit_grants", 32'(cnt), 8);
        chk("limit_outstanding", outstanding, 8);
        chk("limit_blocked", req_arready, 0);
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        #1;
        chk("limit_pop_rvalid", req_rvalid, 4'b0001);
        chk("limit_same_cycle", req_arready, 0);
        tick();
        m_axi_rvalid = 1'b0;
        #1;
        chk("limit_reopen", req_arready, 4'b0001);
        tick();
        req_arvalid = '0;
        #1;
        chk("limit_refill", outstanding, 8);
        m_axi_rvalid = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        #1;
        chk("limit_drained", outstanding, 0);
        tick();

        // ---- AR backpressure: client 1 granted, slot held for 5 cycles
        m_axi_arready = 1'b0;
        set_req(2'd1, 64'hABCD00, 8'd7);
        set_req(2'd2, 64'h2222, 8'd1);
        req_arvalid = 4'b0010;
        #1;
        chk("bp_first_grant", req_arready, 4'b0010);
        tick();
        req_arvalid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_no_grant", req_arready, 0);
            chk("bp_araddr", m_axi_araddr, 64'hABCD00);
            chk("bp_arlen", m_axi_arlen, 7);
            tick();
        end
        m_axi_arready = 1'b1;
        #1;
        chk("bp_resume", req_arready, 4'b0100);
        tick();
        req_arvalid = '0;
        #1;
        chk("bp_next_araddr", m_axi_araddr, 64'h2222);
        chk("bp_next_arlen", m_axi_arlen, 1);
        chk("bp_outstanding", outstanding, 2);
        tick();

        // ---- R backpressure: head client 1 stalls every third step
        m_axi_rvalid = 1'b1;
        beat  = 0;
        steps = 0;
        while (beat < 8 && steps < 40) begin
            req_rready  = (steps % 3 == 1) ? 4'b1101 : 4'b1111;
            m_axi_rdata = 512'(beat + 100);
            m_axi_rlast = (beat == 7);
            #1;
            chk("rbp_rready", m_axi_rready, req_rready[1]);
            chk("rbp_rvalid", req_rvalid, 4'b0010);
            chk("rbp_rdata", req_rdata, 512'(beat + 100));
            if (req_rready[1]) beat++;
            steps++;
            tick();
        end
        chk("rbp_beats", 32'(beat), 8);
        chk("rbp_out", outstanding, 1);
        req_rready = 4'b1111;
        for (int b = 0; b < 2; b++) begin
            m_axi_rlast = (b == 1);
            #1;
            chk("rbp_c2_route", req_rvalid, 4'b0100);
            tick();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        #1;
        chk("rbp_drained", outstanding, 0);

        // ---- unexpected R with empty FIFO
        m_axi_rvalid = 1'b1;
        #1;
        chk("err_rready", m_axi_rready, 0);
        chk("err_rvalid", req_rvalid, 0);
        chk("err_not_yet", err_unexpected_r, 0);
        tick();
        chk("err_set", err_unexpected_r, 1);
        m_axi_rvalid = 1'b0;
        tick();
        chk("err_sticky", err_unexpected_r, 1);

        // ---- reset mid-burst
        set_req(2'd3, 64'h3000, 8'd3);
        req_arvalid = 4'b1000;
        tick();
        req_arvalid  = '0;
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b0;
        tick();
        chk("mid_out", outstanding, 1);
        chk("mid_rvalid", req_rvalid, 4'b1000);
        #2;
        areset = 1'b1;
        #1;
        chk("arst_arvalid", m_axi_arvalid, 0);
        chk("arst_araddr", m_axi_araddr, 0);
        chk("arst_arlen", m_axi_arlen, 0);
        chk("arst_out", outstanding, 0);
        chk("arst_err", err_unexpected_r, 0);
        chk("arst_rready", m_axi_rready, 0);
        chk("arst_rvalid", req_rvalid, 0);
        chk("arst_idle", idle, 1);
        m_axi_rvalid = 1'b0;
        tick();
        areset = 1'b0;
        req_arvalid = 4'b1111;
        #1;
        chk("arst_rr_ptr0", req_arready, 4'b0001);
        tick();
        req_arvalid = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
